uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_tx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and divider helper
// Purpose : parity mode codes and framing FSM encoding shared by TX and RX.
// Contents: PAR_NONE/PAR_ODD/PAR_EVEN, uart_state_t, calc_div().
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with occupancy level
// Purpose : power-of-2 deep FIFO, head word visible on pop_data (show-ahead).
// Ports   : clk, rst_n (async active-low), push/push_data, pop/pop_data,
//           full, empty, level (0..DEPTH).
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with transmit FIFO
// Purpose : frames FIFO words as start/data(LSB first)/parity/stop on rs232_tx.
// Ports   : clk, rst_n (async active-low); tx_data/tx_valid/tx_ready write side;
//           rs232_tx serial line (idle high); busy; fifo_level;
//           send_complete one-cycle pulse when the line goes idle.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          rs232_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          send_complete
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(STOP_BITS * DIV) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * DIV - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD gives fewer than 2 clocks per bit");
  end

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 rdy_en;
  logic                 line_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  // rdy_en holds tx_ready low for the first clock after reset release.
  assign tx_ready = rdy_en && !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign pop      = !fifo_empty &&
                    ((state == S_IDLE) || (state == S_STOP && cnt == STOP_LAST));
  assign busy     = (state != S_IDLE) || !fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shreg[0];
      S_PARITY: line_bit = par_bit;
      default:  line_bit = 1'b1;
    endcase
  end

  // rs232_tx is a register stage behind the FSM, giving the start bit
  // on the 2nd edge after accept while keeping every bit DIV clocks long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      rdy_en        <= 1'b0;
      rs232_tx      <= 1'b1;
      send_complete <= 1'b0;
    end else begin
      rdy_en        <= 1'b1;
      rs232_tx      <= line_bit;
      send_complete <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state   <= S_START;
            cnt     <= '0;
            shreg   <= head;
            par_bit <= (PARITY == PAR_EVEN) ? ^head : ~^head;
          end
        end
        S_START: begin
          if (cnt == BIT_LAST) begin
            state   <= S_DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            state <= S_STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == STOP_LAST) begin
            cnt <= '0;
            if (!fifo_empty) begin
              state   <= S_START;
              shreg   <= head;
              par_bit <= (PARITY == PAR_EVEN) ? ^head : ~^head;
            end else begin
              state         <= S_IDLE;
              send_complete <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat = '0;
  logic       vld = 1'b0;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;
  logic       exp_q [$];

  always #5 clk = ~clk;

  logic       rdy0, tx0, busy0, sc0;
  logic [2:0] lvl0;
  logic       rdy1, tx1, busy1, sc1;
  logic [4:0] lvl1;
  logic       rdy2, tx2, busy2, sc2;
  logic [4:0] lvl2;
  logic       rdy3, tx3, busy3, sc3;
  logic [4:0] lvl3;

  wire v0 = vld && (sel == 0);
  wire v1 = vld && (sel == 1);
  wire v2 = vld && (sel == 2);
  wire v3 = vld && (sel == 3);

  uart_tx_cfg #(.CLK_FREQ(4), .BAUD(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat), .tx_valid(v0), .tx_ready(rdy0),
    .rs232_tx(tx0), .busy(busy0), .fifo_level(lvl0), .send_complete(sc0));
  uart_tx_cfg #(.CLK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[6:0]), .tx_valid(v1), .tx_ready(rdy1),
    .rs232_tx(tx1), .busy(busy1), .fifo_level(lvl1), .send_complete(sc1));
  uart_tx_cfg #(.CLK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat[6:0]), .tx_valid(v2), .tx_ready(rdy2),
    .rs232_tx(tx2), .busy(busy2), .fifo_level(lvl2), .send_complete(sc2));
  uart_tx_cfg #(.CLK_FREQ(4), .BAUD(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat), .tx_valid(v3), .tx_ready(rdy3),
    .rs232_tx(tx3), .busy(busy3), .fifo_level(lvl3), .send_complete(sc3));

  logic line;
  always_comb begin
    case (sel)
      0:       line = tx0;
      1:       line = tx1;
      2:       line = tx2;
      default: line = tx3;
    endcase
  end

  int scn0 = 0, scn1 = 0, scn2 = 0, scn3 = 0;
  always @(posedge clk) begin
    if (sc0) scn0 <= scn0 + 1;
    if (sc1) scn1 <= scn1 + 1;
    if (sc2) scn2 <= scn2 + 1;
    if (sc3) scn3 <= scn3 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] w, input int nb, input int par, input int stops);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(w[i]);
      p = p ^ w[i];
    end
    if (par == 1) exp_q.push_back(~p);
    else if (par == 2) exp_q.push_back(p);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  // Each expected bit must hold for exactly DIV consecutive samples.
  task automatic run_line(input string tag, input int nbits);
    logic e;
    for (int b = 0; b < nbits; b++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      for (int c = 0; c < DIV; c++) begin
        chk($sformatf("%s_bit%0d", tag, b), {31'b0, line}, {31'b0, e});
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_start(input string tag, input int limit);
    int n;
    n = 0;
    while (line !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, line}, 32'd0);
  endtask

  initial begin
    int base;
    int lows;
    logic [7:0] w [6];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'hC3; w[3] = 8'h5A; w[4] = 8'hF0; w[5] = 8'h99;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx0}, 1);
    chk("rst_ready", {31'b0, rdy0}, 0);
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_level", {29'b0, lvl0}, 0);
    chk("rst_sc", {31'b0, sc0}, 0);
    rst_n = 1'b1;
    chk("ready_at_release", {31'b0, rdy0}, 0);
    @(negedge clk);
    chk("ready_after_1clk", {31'b0, rdy0}, 1);
    chk("ready_after_1clk_u3", {31'b0, rdy3}, 1);

    // 8N1 0x55: latency, bit timing, single completion pulse
    sel = 0;
    base = scn0;
    push_frame(8'h55, 8, 0, 1);
    dat = 8'h55; vld = 1'b1;
    @(negedge clk); vld = 1'b0;
    chk("lat_edge0", {31'b0, tx0}, 1);
    @(negedge clk);
    chk("lat_edge1", {31'b0, tx0}, 1);
    @(negedge clk);
    chk("lat_edge2", {31'b0, tx0}, 0);
    run_line("f55", 10);
    repeat (4) @(negedge clk);
    chk("f55_sc_count", scn0 - base, 1);
    chk("f55_idle_busy", {31'b0, busy0}, 0);

    // parity: 7O1 and 7E1 of 0x07
    sel = 1;
    push_frame(8'h07, 7, 1, 1);
    dat = 8'h07; vld = 1'b1;
    @(negedge clk); vld = 1'b0;
    wait_start("odd_start", 10);
    run_line("odd", 10);
    sel = 2;
    push_frame(8'h07, 7, 2, 1);
    dat = 8'h07; vld = 1'b1;
    @(negedge clk); vld = 1'b0;
    wait_start("even_start", 10);
    run_line("even", 10);

    // two stop bits, two words back to back
    sel = 3;
    base = scn3;
    push_frame(8'hA3, 8, 0, 2);
    push_frame(8'h3C, 8, 0, 2);
    dat = 8'hA3; vld = 1'b1;
    @(negedge clk); dat = 8'h3C;
    @(negedge clk); vld = 1'b0;
    wait_start("stop2_start", 10);
    run_line("stop2", 22);
    repeat (4) @(negedge clk);
    chk("stop2_sc_count", scn3 - base, 1);

    // FIFO_DEPTH=4: six pushes, five accepted
    sel = 0;
    base = scn0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          chk($sformatf("depth_ready%0d", i), {31'b0, rdy0}, (i < 5) ? 32'd1 : 32'd0);
          if (i < 5) push_frame(w[i], 8, 0, 1);
          dat = w[i]; vld = 1'b1;
          @(negedge clk);
        end
        vld = 1'b0;
        chk("depth_level_full", {29'b0, lvl0}, 4);
        chk("depth_ready_full", {31'b0, rdy0}, 0);
      end
      begin
        wait_start("depth_start", 20);
        run_line("depth", 50);
      end
    join
    repeat (4) @(negedge clk);
    chk("depth_sc_count", scn0 - base, 1);
    chk("depth_level_drained", {29'b0, lvl0}, 0);

    // simultaneous push and pop at level 2
    fork
      begin
        push_frame(8'h81, 8, 0, 1);
        push_frame(8'h42, 8, 0, 1);
        push_frame(8'h24, 8, 0, 1);
        dat = 8'h81; vld = 1'b1;
        @(negedge clk); dat = 8'h42;
        @(negedge clk); dat = 8'h24;
        @(negedge clk); vld = 1'b0;
        repeat (38) @(negedge clk);
        chk("sim_level_pre", {29'b0, lvl0}, 2);
        push_frame(8'h18, 8, 0, 1);
        dat = 8'h18; vld = 1'b1;
        @(negedge clk); vld = 1'b0;
        chk("sim_level_post", {29'b0, lvl0}, 2);
      end
      begin
        wait_start("sim_start", 20);
        run_line("sim", 40);
      end
    join
    repeat (4) @(negedge clk);

    // reset during data bit 3 with two words queued
    base = scn0;
    dat = 8'hF0; vld = 1'b1;
    @(negedge clk); dat = 8'h0F;
    @(negedge clk); dat = 8'hAA;
    @(negedge clk); vld = 1'b0;
    repeat (17) @(negedge clk);
    chk("rst_mid_line_pre", {31'b0, tx0}, 0);
    chk("rst_mid_level_pre", {29'b0, lvl0}, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'b0, tx0}, 1);
    chk("rst_mid_level", {29'b0, lvl0}, 0);
    chk("rst_mid_busy", {31'b0, busy0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, rdy0}, 1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx0 !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("rst_mid_no_frames", lows, 0);
    chk("rst_mid_no_sc", scn0 - base, 0);
    chk("rst_mid_level_after", {29'b0, lvl0}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
